// File: rtl/cs_controller_pkg.sv
// rtl/cs_controller_pkg.sv - shared constants, encodings and helpers for the clock-system controller
package cs_controller_pkg;

  localparam logic [15:0] CS_BASE_ADDR = 16'h0160;
  localparam logic [15:0] OFS_CTL0     = 16'h0000;
  localparam logic [15:0] OFS_CTL2     = 16'h0004;
  localparam logic [15:0] OFS_CTL3     = 16'h0006;
  localparam logic [15:0] OFS_CTL4     = 16'h0008;

  localparam logic [7:0] CS_PW    = 8'hA5;
  localparam logic [7:0] CS_PW_RD = 8'h96;

  localparam logic [2:0] SEL_LF  = 3'd0;
  localparam logic [2:0] SEL_DCO = 3'd3;

  localparam int DIV_W   = 3;
  localparam int MAX_DIV = 5;

  typedef enum logic {LOCKED = 1'b0, UNLOCKED = 1'b1} lock_state_e;
  typedef enum logic {CH_RUN = 1'b0, CH_PEND = 1'b1} ch_state_e;

  // Only SEL_LF picks the LF source; every other code runs from the DCO.
  function automatic logic is_lf(input logic [2:0] sel);
    return sel == SEL_LF;
  endfunction

  // Ticks per half-period minus one; DIV 6 and 7 saturate at MAX_DIV.
  function automatic logic [5:0] div_reload(input logic [DIV_W-1:0] div);
    logic [DIV_W-1:0] d;
    d = (div > DIV_W'(MAX_DIV)) ? DIV_W'(MAX_DIV) : div;
    return 6'((6'd1 << d) - 6'd1);
  endfunction

endpackage

// File: rtl/cs_controller_clk_channel.sv
// rtl/cs_controller_clk_channel.sv - one clock channel: tick mux, divider counter, toggle flop, RUN/PEND switch FSM
module cs_clk_channel
  import cs_controller_pkg::*;
#(
  parameter logic [2:0] RST_SEL = SEL_DCO
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dco_tick,
  input  logic             lf_tick,
  input  logic             load,
  input  logic [2:0]       new_sel,
  input  logic [DIV_W-1:0] new_div,
  input  logic             off,
  output logic             clk_out,
  output logic             pending,
  output logic [2:0]       pend_sel,
  output logic [DIV_W-1:0] pend_div
);

  ch_state_e        state, state_nx;
  logic [2:0]       cur_sel;
  logic [DIV_W-1:0] cur_div;
  logic [5:0]       cnt, reload_nx;
  logic             clk_q, held_q;
  logic             tick, fall, commit, src_chg;

  // Tick mux, commit detection and next switch state
  always_comb begin
    tick      = is_lf(cur_sel) ? lf_tick : dco_tick;
    fall      = tick && (cnt == 6'd0) && clk_q && !held_q;
    commit    = (state == CH_PEND) && (fall || (tick && held_q));
    src_chg   = is_lf(cur_sel) != is_lf(pend_sel);
    // A source change gets one extra tick so the first partial tick never shortens the phase
    reload_nx = commit ? 6'(div_reload(pend_div) + {5'd0, src_chg}) : div_reload(cur_div);
    state_nx  = state;
    if (load && ((new_sel != pend_sel) || (new_div != pend_div)))
      state_nx = CH_PEND;
    else if (commit)
      state_nx = CH_RUN;
  end

  // Switch FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= CH_RUN;
    else       state <= state_nx;
  end

  // Config latches, divider counter and output toggle
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_sel <= RST_SEL;
      pend_div <= '0;
      cur_sel  <= RST_SEL;
      cur_div  <= '0;
      cnt      <= 6'd0;
      clk_q    <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      if (load) begin
        pend_sel <= new_sel;
        pend_div <= new_div;
      end
      if (commit) begin
        cur_sel <= pend_sel;
        cur_div <= pend_div;
      end
      if (tick) begin
        if (held_q) begin
          if (!off) begin
            held_q <= 1'b0;
            cnt    <= reload_nx;
          end
        end else if (cnt == 6'd0) begin
          clk_q  <= ~clk_q;
          held_q <= clk_q & off;
          cnt    <= reload_nx;
        end else begin
          cnt <= 6'(cnt - 6'd1);
        end
      end
    end
  end

  assign clk_out = clk_q;
  assign pending = (state == CH_PEND);

endmodule

// File: rtl/cs_controller.sv
// rtl/cs_controller.sv - CS register file, password lock and three clock channels; optional CS_SMCLK_OFF_EN adds CSCTL4.SMCLKOFF
module cs_controller
  import cs_controller_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = CS_BASE_ADDR
) (
  input  logic        sysOsc,
  input  logic        reset,
  input  logic        dco_tick,
  input  logic        lf_tick,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [15:0] rdata,
  output logic        MCLK,
  output logic        SMCLK,
  output logic        ACLK,
  output logic        pw_violation
);

  localparam logic [15:0] A_CTL0 = BASE_ADDR + OFS_CTL0;
  localparam logic [15:0] A_CTL2 = BASE_ADDR + OFS_CTL2;
  localparam logic [15:0] A_CTL3 = BASE_ADDR + OFS_CTL3;
  localparam logic [15:0] A_CTL4 = BASE_ADDR + OFS_CTL4;

  lock_state_e      lock_q, lock_nx;
  logic             viol_nx;
  logic             hit0, hit2, hit3, hit4, wr_ok, ld2, ld3;
  logic             smclk_off;
  logic [2:0]       psel [3];
  logic [DIV_W-1:0] pdiv [3];
  logic [2:0]       pend, clk_o;
  logic [15:0]      rd_mux;
  logic             unused_bits;

  assign hit0  = addr[15:1] == A_CTL0[15:1];
  assign hit2  = addr[15:1] == A_CTL2[15:1];
  assign hit3  = addr[15:1] == A_CTL3[15:1];
  assign hit4  = addr[15:1] == A_CTL4[15:1];
  assign wr_ok = we && (lock_q == UNLOCKED);
  assign ld2   = wr_ok && hit2;
  assign ld3   = wr_ok && hit3;
  assign unused_bits = ^{addr[0], wdata[7], wdata[3]};

  // Lock next-state and violation detection
  always_comb begin
    lock_nx = lock_q;
    viol_nx = 1'b0;
    if (we) begin
      if (hit0) begin
        if (wdata[15:8] == CS_PW) begin
          lock_nx = UNLOCKED;
        end else begin
          lock_nx = LOCKED;
          viol_nx = 1'b1;
        end
      end else if ((hit2 || hit3 || hit4) && (lock_q == LOCKED)) begin
        viol_nx = 1'b1;
      end
    end
  end

  // Lock state register and registered violation pulse
  always_ff @(posedge sysOsc) begin
    if (reset) begin
      lock_q       <= LOCKED;
      pw_violation <= 1'b0;
    end else begin
      lock_q       <= lock_nx;
      pw_violation <= viol_nx;
    end
  end

`ifdef CS_SMCLK_OFF_EN
  // SMCLKOFF control bit, lock protected
  always_ff @(posedge sysOsc) begin
    if (reset)              smclk_off <= 1'b0;
    else if (wr_ok && hit4) smclk_off <= wdata[1];
  end
`else
  assign smclk_off = 1'b0;
`endif

  // Channel 0 = MCLK, 1 = SMCLK, 2 = ACLK; field i sits at bits [4i+2:4i]
  for (genvar i = 0; i < 3; i++) begin : g_ch
    cs_clk_channel #(
      .RST_SEL((i == 2) ? SEL_LF : SEL_DCO)
    ) u_ch (
      .clk      (sysOsc),
      .reset    (reset),
      .dco_tick (dco_tick),
      .lf_tick  (lf_tick),
      .load     (ld2 | ld3),
      .new_sel  (ld2 ? wdata[4*i +: 3] : psel[i]),
      .new_div  (ld3 ? wdata[4*i +: 3] : pdiv[i]),
      .off      ((i == 1) ? smclk_off : 1'b0),
      .clk_out  (clk_o[i]),
      .pending  (pend[i]),
      .pend_sel (psel[i]),
      .pend_div (pdiv[i])
    );
  end

  assign MCLK  = clk_o[0];
  assign SMCLK = clk_o[1];
  assign ACLK  = clk_o[2];

  // Readback mux; unmapped addresses read zero
  always_comb begin
    rd_mux = 16'h0000;
    if (hit0)      rd_mux = {CS_PW_RD, 8'h00};
    else if (hit2) rd_mux = {|pend, 4'b0, psel[2], 1'b0, psel[1], 1'b0, psel[0]};
    else if (hit3) rd_mux = {5'b0, pdiv[2], 1'b0, pdiv[1], 1'b0, pdiv[0]};
    else if (hit4) rd_mux = {14'b0, smclk_off, 1'b0};
  end

  // Registered read data
  always_ff @(posedge sysOsc) begin
    if (reset)   rdata <= 16'h0000;
    else if (re) rdata <= rd_mux;
  end

endmodule

// File: tb/tb_cs_controller.sv
// tb/tb_cs_controller.sv - directed self-checking bench for cs_controller
`timescale 1ns/1ps
module tb_cs_controller;

  localparam logic [15:0] A0 = 16'h0160, A2 = 16'h0164, A3 = 16'h0166, A4 = 16'h0168;

  logic        sysOsc = 1'b0, reset = 1'b1, dco_tick = 1'b0, lf_tick = 1'b0;
  logic        we = 1'b0, re = 1'b0;
  logic [15:0] addr = 16'h0000, wdata = 16'h0000;
  logic [15:0] rdata;
  logic        MCLK, SMCLK, ACLK, pw_violation;
  int          n_cmp = 0, n_bad = 0;
  logic        last_pw;

  cs_controller dut (
    .sysOsc(sysOsc), .reset(reset), .dco_tick(dco_tick), .lf_tick(lf_tick),
    .addr(addr), .wdata(wdata), .we(we), .re(re), .rdata(rdata),
    .MCLK(MCLK), .SMCLK(SMCLK), .ACLK(ACLK), .pw_violation(pw_violation)
  );

  always #42 sysOsc = ~sysOsc;

  initial begin : tick_gen
    int c;
    c = 0;
    forever begin
      @(posedge sysOsc); #1;
      dco_tick = (c % 6) == 5;
      lf_tick  = (c % 183) == 182;
      c++;
    end
  end

  initial begin : watchdog
    #(84 * 60000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic pick(input int c);
    if (c == 0) return MCLK;
    if (c == 1) return SMCLK;
    return ACLK;
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(posedge sysOsc); #1; addr = a; wdata = d; we = 1'b1;
    @(posedge sysOsc); #1; we = 1'b0; last_pw = pw_violation;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(posedge sysOsc); #1; addr = a; re = 1'b1;
    @(posedge sysOsc); #1; re = 1'b0; d = rdata;
  endtask

  task automatic wait_edge(input int c, input logic lvl, input int budget, output bit ok);
    logic prev;
    prev = pick(c);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge sysOsc);
      if (pick(c) === lvl && prev !== lvl) begin ok = 1'b1; return; end
      prev = pick(c);
    end
  endtask

  task automatic count_level(input int c, input logic lvl, output int n);
    n = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sysOsc);
      if (pick(c) !== lvl) return;
      n++;
    end
    n = -1;
  endtask

  task automatic measure(input int c, output int hi, output int lo);
    bit ok;
    wait_edge(c, 1'b1, 1000, ok);
    if (!ok) begin hi = -1; lo = -1; return; end
    count_level(c, 1'b1, hi);
    count_level(c, 1'b0, lo);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge sysOsc);
    #1;
    n_cmp++; if (MCLK !== 1'b0) begin n_bad++; $display("FAIL reset_mclk: got %b want 0", MCLK); end
    n_cmp++; if (SMCLK !== 1'b0) begin n_bad++; $display("FAIL reset_smclk: got %b want 0", SMCLK); end
    n_cmp++; if (ACLK !== 1'b0) begin n_bad++; $display("FAIL reset_aclk: got %b want 0", ACLK); end
    n_cmp++; if (pw_violation !== 1'b0) begin n_bad++; $display("FAIL reset_pw: got %b want 0", pw_violation); end
    n_cmp++; if (rdata !== 16'h0000) begin n_bad++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    reset = 1'b0;
  endtask

  task automatic test_default_clocks;
    int hi, lo, diff;
    logic [15:0] d;
    measure(0, hi, lo);
    n_cmp++; if (hi !== 6 || lo !== 6) begin n_bad++; $display("FAIL dflt_mclk: got %0d/%0d want 6/6", hi, lo); end
    measure(1, hi, lo);
    n_cmp++; if (hi !== 6 || lo !== 6) begin n_bad++; $display("FAIL dflt_smclk: got %0d/%0d want 6/6", hi, lo); end
    measure(2, hi, lo);
    n_cmp++; if (hi !== 183 || lo !== 183) begin n_bad++; $display("FAIL dflt_aclk: got %0d/%0d want 183/183", hi, lo); end
    diff = 0;
    repeat (24) begin @(negedge sysOsc); if (MCLK !== SMCLK) diff++; end
    n_cmp++; if (diff !== 0) begin n_bad++; $display("FAIL dflt_phase: got %0d differing samples want 0", diff); end
    bus_read(A2, d);
    n_cmp++; if (d !== 16'h0033) begin n_bad++; $display("FAIL dflt_ctl2: got %h want 0033", d); end
    bus_read(A3, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL dflt_ctl3: got %h want 0000", d); end
    bus_read(A0, d);
    n_cmp++; if (d !== 16'h9600) begin n_bad++; $display("FAIL dflt_ctl0: got %h want 9600", d); end
    bus_read(16'h0162, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL unmapped: got %h want 0000", d); end
  endtask

  task automatic test_locked_write;
    int hi, lo;
    logic [15:0] d;
    bus_write(A3, 16'h0002);
    n_cmp++; if (last_pw !== 1'b1) begin n_bad++; $display("FAIL locked_pw: got %b want 1", last_pw); end
    @(posedge sysOsc); #1;
    n_cmp++; if (pw_violation !== 1'b0) begin n_bad++; $display("FAIL locked_pw_pulse: got %b want 0", pw_violation); end
    bus_read(A3, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL locked_ctl3: got %h want 0000", d); end
    measure(0, hi, lo);
    n_cmp++; if (hi !== 6 || lo !== 6) begin n_bad++; $display("FAIL locked_mclk: got %0d/%0d want 6/6", hi, lo); end
  endtask

  task automatic test_div_switch;
    bit ok;
    int hi, lo;
    logic [15:0] d;
    bus_write(A0, 16'hA500);
    n_cmp++; if (last_pw !== 1'b0) begin n_bad++; $display("FAIL unlock_pw: got %b want 0", last_pw); end
    wait_edge(0, 1'b1, 50, ok);
    bus_write(A3, 16'h0002);
    bus_read(A2, d);
    n_cmp++; if (d !== 16'h8033) begin n_bad++; $display("FAIL div_pending: got %h want 8033", d); end
    wait_edge(0, 1'b0, 50, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL div_fall: got %b want 1", ok); end
    count_level(0, 1'b0, lo);
    count_level(0, 1'b1, hi);
    n_cmp++; if (lo !== 24 || hi !== 24) begin n_bad++; $display("FAIL div4_mclk: got %0d/%0d want 24/24", hi, lo); end
    bus_read(A2, d);
    n_cmp++; if (d !== 16'h0033) begin n_bad++; $display("FAIL div_committed: got %h want 0033", d); end
    bus_read(A3, d);
    n_cmp++; if (d !== 16'h0002) begin n_bad++; $display("FAIL div_ctl3: got %h want 0002", d); end
    bus_write(A3, 16'h0000);
    wait_edge(0, 1'b0, 100, ok);
    count_level(0, 1'b0, lo);
    count_level(0, 1'b1, hi);
    n_cmp++; if (lo !== 6 || hi !== 6) begin n_bad++; $display("FAIL div_restore: got %0d/%0d want 6/6", hi, lo); end
  endtask

  task automatic test_sel_replace;
    bit ok;
    int hi, lo;
    logic [15:0] d;
    wait_edge(1, 1'b1, 50, ok);
    bus_write(A2, 16'h0003);
    bus_write(A2, 16'h0033);
    wait_edge(1, 1'b0, 50, ok);
    count_level(1, 1'b0, lo);
    count_level(1, 1'b1, hi);
    n_cmp++; if (lo !== 6 || hi !== 6) begin n_bad++; $display("FAIL replace_smclk: got %0d/%0d want 6/6", hi, lo); end
    bus_read(A2, d);
    n_cmp++; if (d !== 16'h0033) begin n_bad++; $display("FAIL replace_ctl2: got %h want 0033", d); end
  endtask

  task automatic test_div_saturate;
    bit ok;
    int hi, lo;
    logic [15:0] d;
    bus_write(A3, 16'h0070);
    wait_edge(1, 1'b0, 50, ok);
    count_level(1, 1'b0, lo);
    count_level(1, 1'b1, hi);
    n_cmp++; if (lo !== 192 || hi !== 192) begin n_bad++; $display("FAIL div7_smclk: got %0d/%0d want 192/192", hi, lo); end
    bus_read(A3, d);
    n_cmp++; if (d !== 16'h0070) begin n_bad++; $display("FAIL div7_ctl3: got %h want 0070", d); end
    bus_write(A3, 16'h0000);
    wait_edge(1, 1'b0, 500, ok);
    count_level(1, 1'b0, lo);
    count_level(1, 1'b1, hi);
    n_cmp++; if (lo !== 6 || hi !== 6) begin n_bad++; $display("FAIL div7_restore: got %0d/%0d want 6/6", hi, lo); end
  endtask

  task automatic test_aclk_source;
    bit ok;
    int hi, lo;
    logic [15:0] d;
    bus_write(A2, 16'h0333);
    wait_edge(2, 1'b0, 500, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL aclk_fall: got %b want 1", ok); end
    count_level(2, 1'b0, lo);
    n_cmp++; if (!(lo >= 7 && lo <= 12)) begin n_bad++; $display("FAIL aclk_first_low: got %0d want 7..12", lo); end
    count_level(2, 1'b1, hi);
    count_level(2, 1'b0, lo);
    n_cmp++; if (hi !== 6 || lo !== 6) begin n_bad++; $display("FAIL aclk_dco: got %0d/%0d want 6/6", hi, lo); end
    bus_read(A2, d);
    n_cmp++; if (d !== 16'h0333) begin n_bad++; $display("FAIL aclk_ctl2: got %h want 0333", d); end
  endtask

  task automatic test_relock;
    int hi, lo;
    logic [15:0] d;
    bus_write(A0, 16'h1200);
    n_cmp++; if (last_pw !== 1'b1) begin n_bad++; $display("FAIL relock_pw: got %b want 1", last_pw); end
    bus_write(A2, 16'h0000);
    n_cmp++; if (last_pw !== 1'b1) begin n_bad++; $display("FAIL relock_write_pw: got %b want 1", last_pw); end
    bus_read(A2, d);
    n_cmp++; if (d !== 16'h0333) begin n_bad++; $display("FAIL relock_ctl2: got %h want 0333", d); end
    measure(2, hi, lo);
    n_cmp++; if (hi !== 6 || lo !== 6) begin n_bad++; $display("FAIL relock_aclk: got %0d/%0d want 6/6", hi, lo); end
  endtask

  task automatic test_smclk_off;
    logic [15:0] d;
`ifdef CS_SMCLK_OFF_EN
    bit ok;
    int hi, lo, highs;
    bus_write(A0, 16'hA500);
    bus_write(A4, 16'h0002);
    n_cmp++; if (last_pw !== 1'b0) begin n_bad++; $display("FAIL off_pw: got %b want 0", last_pw); end
    wait_edge(1, 1'b0, 50, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL off_fall: got %b want 1", ok); end
    bus_read(A4, d);
    n_cmp++; if (d !== 16'h0002) begin n_bad++; $display("FAIL off_ctl4: got %h want 0002", d); end
    highs = 0;
    repeat (60) begin @(negedge sysOsc); if (SMCLK !== 1'b0) highs++; end
    n_cmp++; if (highs !== 0) begin n_bad++; $display("FAIL off_held: got %0d high samples want 0", highs); end
    measure(0, hi, lo);
    n_cmp++; if (hi !== 6 || lo !== 6) begin n_bad++; $display("FAIL off_mclk: got %0d/%0d want 6/6", hi, lo); end
    bus_write(A4, 16'h0000);
    measure(1, hi, lo);
    n_cmp++; if (hi !== 6 || lo !== 6) begin n_bad++; $display("FAIL off_resume: got %0d/%0d want 6/6", hi, lo); end
`else
    bus_write(A0, 16'hA500);
    bus_write(A4, 16'h0002);
    n_cmp++; if (last_pw !== 1'b0) begin n_bad++; $display("FAIL ctl4_unlocked_pw: got %b want 0", last_pw); end
    bus_read(A4, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL ctl4_reads0: got %h want 0000", d); end
    bus_write(A0, 16'h0000);
    bus_write(A4, 16'h0002);
    n_cmp++; if (last_pw !== 1'b1) begin n_bad++; $display("FAIL ctl4_locked_pw: got %b want 1", last_pw); end
`endif
  endtask

  task automatic test_reset_mid;
    int hi, lo;
    logic [15:0] d;
    bus_write(A0, 16'hA500);
    bus_write(A3, 16'h0002);
    reset = 1'b1;
    @(posedge sysOsc); #1;
    n_cmp++; if ({MCLK, SMCLK, ACLK} !== 3'b000) begin n_bad++; $display("FAIL mid_clocks: got %b want 000", {MCLK, SMCLK, ACLK}); end
    @(posedge sysOsc); #1;
    reset = 1'b0;
    bus_read(A3, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL mid_ctl3: got %h want 0000", d); end
    bus_read(A2, d);
    n_cmp++; if (d !== 16'h0033) begin n_bad++; $display("FAIL mid_ctl2: got %h want 0033", d); end
    bus_write(A3, 16'h0002);
    n_cmp++; if (last_pw !== 1'b1) begin n_bad++; $display("FAIL mid_locked: got %b want 1", last_pw); end
    measure(0, hi, lo);
    n_cmp++; if (hi !== 6 || lo !== 6) begin n_bad++; $display("FAIL mid_mclk: got %0d/%0d want 6/6", hi, lo); end
    measure(2, hi, lo);
    n_cmp++; if (hi !== 183 || lo !== 183) begin n_bad++; $display("FAIL mid_aclk: got %0d/%0d want 183/183", hi, lo); end
  endtask

  initial begin
    test_reset();
    test_default_clocks();
    test_locked_write();
    test_div_switch();
    test_sel_replace();
    test_div_saturate();
    test_aclk_source();
    test_relock();
    test_smclk_off();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
